// File: rtl/mac_result_collector.sv
// Result-stream collector for the square-accumulate datapath: frames results,
// flags accumulator wrap-around, and buffers tagged words toward a ready/valid sink.
module mac_result_collector #(
  parameter int DATA_W    = 20,
  parameter int DEPTH     = 8,
  parameter int FRAME_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] f_in,
  input  logic              f_valid,
  output logic              acc_clear,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_wrap,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              overflow,
  output logic              wrap_seen,
  output logic [7:0]        drop_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int ENT_W = DATA_W + 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);
  localparam logic [PTR_W:0]   FULL_OCC = (PTR_W + 1)'(DEPTH);

  // Entry layout: {wrap, last, data}
  logic [ENT_W-1:0]  mem_q [DEPTH];
  logic [ENT_W-1:0]  head;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    occ_q, occ_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] prev_f_q, prev_f_d;
  logic              frame_wrap_q, frame_wrap_d;
  logic              wrap_seen_q, wrap_seen_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_count_q, drop_count_d;
  logic              acc_clear_q, acc_clear_d;

  logic is_last, detect, tag_wrap, full, push, pop, drop;

  always_comb begin
    is_last  = f_valid && (cnt_q == LAST_CNT);
    // prev_f is zero at frame start, so the first sample can never compare low.
    detect   = f_valid && (cnt_q != '0) && (f_in < prev_f_q);
    tag_wrap = frame_wrap_q || detect;
    full     = (occ_q == FULL_OCC);
    pop      = (occ_q != '0) && out_ready;
    push     = f_valid && (!full || pop);
    drop     = f_valid && full && !pop;

    cnt_d        = cnt_q;
    prev_f_d     = prev_f_q;
    frame_wrap_d = frame_wrap_q;
    if (f_valid) begin
      cnt_d        = is_last ? '0 : cnt_q + 1'b1;
      prev_f_d     = is_last ? '0 : f_in;
      frame_wrap_d = is_last ? 1'b0 : tag_wrap;
    end

    acc_clear_d  = is_last;
    wrap_seen_d  = wrap_seen_q || detect;
    overflow_d   = overflow_q || drop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 8'hFF)) drop_count_d = drop_count_q + 8'd1;

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    occ_d    = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      cnt_q        <= '0;
      prev_f_q     <= '0;
      frame_wrap_q <= 1'b0;
      wrap_seen_q  <= 1'b0;
      overflow_q   <= 1'b0;
      drop_count_q <= 8'd0;
      acc_clear_q  <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      occ_q        <= occ_d;
      cnt_q        <= cnt_d;
      prev_f_q     <= prev_f_d;
      frame_wrap_q <= frame_wrap_d;
      wrap_seen_q  <= wrap_seen_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
      acc_clear_q  <= acc_clear_d;
    end
  end

  // Storage needs no reset; stale contents are masked by out_valid below.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {tag_wrap, is_last, f_in};
  end

  assign head       = mem_q[rd_ptr_q];
  assign out_valid  = (occ_q != '0);
  assign out_data   = out_valid ? head[DATA_W-1:0] : '0;
  assign out_last   = out_valid && head[DATA_W];
  assign out_wrap   = out_valid && head[DATA_W+1];
  assign acc_clear  = acc_clear_q;
  assign overflow   = overflow_q;
  assign wrap_seen  = wrap_seen_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_mac_result_collector.sv
// Directed bench for mac_result_collector: framing, wrap tagging, FIFO drop/full
// behaviour and mid-frame reset, with hand-computed expectations.
module tb_mac_result_collector;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] f_in = '0;
  logic        f_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        acc_clear, out_last, out_wrap, out_valid, overflow, wrap_seen;
  logic [19:0] out_data;
  logic [7:0]  drop_count;

  int tests = 0;
  int fails = 0;

  mac_result_collector #(.DATA_W(20), .DEPTH(8), .FRAME_LEN(16)) dut (
    .clk(clk), .reset(reset), .f_in(f_in), .f_valid(f_valid),
    .acc_clear(acc_clear), .out_data(out_data), .out_last(out_last),
    .out_wrap(out_wrap), .out_valid(out_valid), .out_ready(out_ready),
    .overflow(overflow), .wrap_seen(wrap_seen), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 ns after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; f_valid = 1'b0; out_ready = 1'b0; f_in = '0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({out_valid, out_last, out_wrap, acc_clear, overflow, wrap_seen} !== 6'b0) begin
      fails++; $display("FAIL reset_flags got=%b exp=000000",
        {out_valid, out_last, out_wrap, acc_clear, overflow, wrap_seen});
    end
    tests++;
    if (out_data !== 20'd0 || drop_count !== 8'd0) begin
      fails++; $display("FAIL reset_data got data=%0h drops=%0d exp 0/0", out_data, drop_count);
    end
    out_ready = 1'b1;
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL empty_pop got out_valid=%b exp=0", out_valid);
    end
    $display("[TB] test_reset done");
  endtask

  task automatic test_basic();
    logic [19:0] v [3];
    v[0] = 20'd1; v[1] = 20'd5; v[2] = 20'd14;
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f_valid = 1'b1; f_in = v[i];
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== v[i] || out_last !== 1'b0 ||
          out_wrap !== 1'b0 || acc_clear !== 1'b0) begin
        fails++; $display("FAIL basic[%0d] got v=%b d=%0d l=%b w=%b c=%b exp v=1 d=%0d l=0 w=0 c=0",
          i, out_valid, out_data, out_last, out_wrap, acc_clear, v[i]);
      end
    end
    f_valid = 1'b0;
    tick();
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL basic_drain got out_valid=%b exp=0", out_valid);
    end
    $display("[TB] test_basic done");
  endtask

  task automatic test_frame();
    int s = 0;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      s += k * k;
      f_valid = 1'b1; f_in = 20'(s);
      tick();
      tests++;
      if (out_valid !== 1'b1 || out_data !== 20'(s) || out_last !== (k == 15) ||
          out_wrap !== 1'b0 || acc_clear !== (k == 15)) begin
        fails++; $display("FAIL frame[%0d] got d=%0d l=%b w=%b c=%b exp d=%0d l=%b w=0 c=%b",
          k, out_data, out_last, out_wrap, acc_clear, s, (k == 15), (k == 15));
      end
    end
    f_valid = 1'b0;
    tick();
    tests++;
    if (acc_clear !== 1'b0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL frame_clear_pulse got c=%b v=%b exp 0/0", acc_clear, out_valid);
    end
    // Counter back at 0: a fresh frame needs 16 more samples before acc_clear.
    for (int k = 0; k < 16; k++) begin
      f_valid = 1'b1; f_in = 20'(k);
      tick();
      tests++;
      if (acc_clear !== (k == 15)) begin
        fails++; $display("FAIL frame2_clear[%0d] got=%b exp=%b", k, acc_clear, (k == 15));
      end
    end
    f_valid = 1'b0;
    tick();
    $display("[TB] test_frame done");
  endtask

  task automatic test_wrap();
    logic [19:0] v;
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      v = (k == 0) ? 20'hFFFF0 : 20'(16 * k);
      f_valid = 1'b1; f_in = v;
      tick();
      tests++;
      if (out_data !== v || out_wrap !== (k != 0) || wrap_seen !== (k != 0) ||
          out_last !== (k == 15)) begin
        fails++; $display("FAIL wrap[%0d] got d=%0h w=%b seen=%b l=%b exp d=%0h w=%b seen=%b l=%b",
          k, out_data, out_wrap, wrap_seen, out_last, v, (k != 0), (k != 0), (k == 15));
      end
    end
    for (int k = 0; k < 2; k++) begin
      f_valid = 1'b1; f_in = 20'(5 + k);
      tick();
      tests++;
      if (out_data !== 20'(5 + k) || out_wrap !== 1'b0 || wrap_seen !== 1'b1) begin
        fails++; $display("FAIL wrap_next[%0d] got d=%0d w=%b seen=%b exp d=%0d w=0 seen=1",
          k, out_data, out_wrap, wrap_seen, 5 + k);
      end
    end
    f_valid = 1'b0;
    tick();
    $display("[TB] test_wrap done");
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      f_valid = 1'b1; f_in = 20'(100 + i);
      tick();
      tests++;
      if (overflow !== (i >= 8) || drop_count !== 8'((i >= 8) ? i - 7 : 0) || out_data !== 20'd100) begin
        fails++; $display("FAIL ovf_fill[%0d] got o=%b n=%0d d=%0d exp o=%b n=%0d d=100",
          i, overflow, drop_count, out_data, (i >= 8), (i >= 8) ? i - 7 : 0);
      end
    end
    f_valid = 1'b0;
    tick();
    tests++;
    if (out_data !== 20'd100 || out_valid !== 1'b1 || drop_count !== 8'd2) begin
      fails++; $display("FAIL ovf_hold got d=%0d v=%b n=%0d exp d=100 v=1 n=2", out_data, out_valid, drop_count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_data !== 20'(100 + i)) begin
        fails++; $display("FAIL ovf_drain[%0d] got v=%b d=%0d exp v=1 d=%0d", i, out_valid, out_data, 100 + i);
      end
      tick();
    end
    tests++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      fails++; $display("FAIL ovf_empty got v=%b o=%b exp v=0 o=1", out_valid, overflow);
    end
    $display("[TB] test_overflow done");
  endtask

  task automatic test_full_push_pop();
    logic [19:0] exp_v;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      f_valid = 1'b1; f_in = 20'(200 + i);
      tick();
    end
    f_valid = 1'b1; f_in = 20'd300; out_ready = 1'b1;
    tick();
    tests++;
    if (drop_count !== 8'd0 || overflow !== 1'b0 || out_data !== 20'd201) begin
      fails++; $display("FAIL full_pp got n=%0d o=%b d=%0d exp n=0 o=0 d=201", drop_count, overflow, out_data);
    end
    // Still full: one more push without a pop must drop.
    f_in = 20'd301; out_ready = 1'b0;
    tick();
    tests++;
    if (drop_count !== 8'd1) begin
      fails++; $display("FAIL full_still got n=%0d exp=1", drop_count);
    end
    f_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_v = (i == 7) ? 20'd300 : 20'(201 + i);
      tests++;
      if (out_valid !== 1'b1 || out_data !== exp_v) begin
        fails++; $display("FAIL full_drain[%0d] got v=%b d=%0d exp v=1 d=%0d", i, out_valid, out_data, exp_v);
      end
      tick();
    end
    tests++;
    if (out_valid !== 1'b0) begin
      fails++; $display("FAIL full_empty got v=%b exp=0", out_valid);
    end
    $display("[TB] test_full_push_pop done");
  endtask

  task automatic test_drop_last_and_saturate();
    do_reset();
    for (int i = 0; i < 270; i++) begin
      f_valid = 1'b1; f_in = 20'(i);
      tick();
      if (i == 15) begin
        tests++;
        if (acc_clear !== 1'b1 || drop_count !== 8'd8) begin
          fails++; $display("FAIL drop_last got c=%b n=%0d exp c=1 n=8", acc_clear, drop_count);
        end
      end
      if (i == 261) begin
        tests++;
        if (drop_count !== 8'd254) begin
          fails++; $display("FAIL sat_pre got n=%0d exp=254", drop_count);
        end
      end
    end
    tests++;
    if (drop_count !== 8'd255 || overflow !== 1'b1) begin
      fails++; $display("FAIL sat_end got n=%0d o=%b exp n=255 o=1", drop_count, overflow);
    end
    f_valid = 1'b0;
    $display("[TB] test_drop_last_and_saturate done");
  endtask

  task automatic test_reset_mid();
    logic [19:0] v [5];
    v[0] = 20'd50; v[1] = 20'd40; v[2] = 20'd60; v[3] = 20'd70; v[4] = 20'd80;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      f_valid = 1'b1; f_in = v[i];
      tick();
    end
    tests++;
    if (wrap_seen !== 1'b1 || out_valid !== 1'b1) begin
      fails++; $display("FAIL mid_pre got seen=%b v=%b exp 1/1", wrap_seen, out_valid);
    end
    reset = 1'b1; f_valid = 1'b0;
    tick();
    reset = 1'b0;
    tests++;
    if ({out_valid, out_last, out_wrap, acc_clear, overflow, wrap_seen} !== 6'b0 ||
        out_data !== 20'd0 || drop_count !== 8'd0) begin
      fails++; $display("FAIL mid_reset got flags=%b d=%0d n=%0d exp 0",
        {out_valid, out_last, out_wrap, acc_clear, overflow, wrap_seen}, out_data, drop_count);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      f_valid = 1'b1; f_in = 20'(k);
      tick();
      tests++;
      if (acc_clear !== (k == 15) || out_last !== (k == 15)) begin
        fails++; $display("FAIL mid_frame[%0d] got c=%b l=%b exp %b", k, acc_clear, out_last, (k == 15));
      end
    end
    f_valid = 1'b0;
    tick();
    $display("[TB] test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame();
    test_wrap();
    test_overflow();
    test_full_push_pop();
    test_drop_last_and_saturate();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mac_result_collector.md
Name: mac_result_collector

Overview:
Receiving end of the square-accumulate datapath's result stream. Captures every (f, valid_out) result word from the accumulator and groups results into frames of FRAME_LEN samples. Buffers results in a small FIFO toward a downstream ready/valid consumer. Flags accumulator wrap-around and FIFO drops, and pulses acc_clear at each frame end so the accumulator restarts.

Parameters:
DATA_W, 20, width of accumulator result f
DEPTH, 8, FIFO entries (power of 2, >=2)
FRAME_LEN, 16, results per frame (>=2)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
f_in  in  DATA_W  accumulator result
f_valid  in  1  result strobe (accumulator valid_out); no back-pressure upstream
acc_clear  out  1  one-cycle pulse requesting accumulator clear after frame end
out_data  out  DATA_W  FIFO head result
out_last  out  1  head entry is last result of its frame
out_wrap  out  1  head entry's frame had seen a wrap at or before this entry
out_valid  out  1  FIFO non-empty
out_ready  in  1  downstream accepts head when out_valid&&out_ready
overflow  out  1  sticky: at least one result dropped
wrap_seen  out  1  sticky: at least one wrap detected
drop_count  out  8  saturating count of dropped results

Behaviour:
- Interface: reset reset, synchronous, active-high; clock clk. All state changes on posedge clk only.
- Reset values:
  - FIFO empty; out_valid=0; out_data, out_last and out_wrap=0.
  - acc_clear=0; overflow=0; wrap_seen=0; drop_count=0; frame counter=0; prev_f=0; frame_wrap=0.
- Reset mid-operation discards all buffered entries and any partial frame. No acc_clear is issued for the discarded frame.
- Frame counter:
  - Increments on every f_valid, whether the word is accepted or dropped.
  - On the sample where counter==FRAME_LEN-1, that sample is tagged last and the counter returns to 0.
- acc_clear:
  - Registered; high exactly one cycle, in the cycle after the last sample's f_valid.
  - Issued even if that last sample was dropped.
- Wrap detection:
  - Within a frame, results must be non-decreasing, since each step adds a*a >= 0.
  - If f_valid and f_in < prev_f: set frame_wrap and wrap_seen.
  - Tag bit out_wrap = frame_wrap OR the current detection.
  - prev_f <= f_in on every f_valid. At the last sample, prev_f and frame_wrap both reset to 0.
  - The first sample of a frame is never flagged.
- FIFO:
  - Entry = {wrap, last, f_in}. Push on f_valid; pop on out_valid&&out_ready.
  - out_data/out_last/out_wrap are read combinationally from the head entry.
  - Latency: a word pushed in cycle N is visible with out_valid=1 in cycle N+1 when the FIFO was empty (no fall-through in the same cycle).
  - Full and pushing with no pop in the same cycle: drop the word, set overflow, drop_count += 1 (saturate at 255).
  - Full with a simultaneous pop and push: both occur, no drop, count unchanged.
  - Empty: out_valid=0; out_ready is ignored; no underflow.
  - Pointers wrap modulo DEPTH; occupancy counter ranges 0..DEPTH.
- out_data is held stable while out_valid && !out_ready.

Test Plan:
- Reset, then f_valid with f_in=1,5,14 on consecutive cycles, out_ready=1:
  - out_data=1,5,14 appear one cycle after each input.
  - out_last=0, out_wrap=0, acc_clear stays 0.
- 16 samples of f_in=k*k-sum (0,1,5,...,1240), out_ready=1:
  - 16th output has out_last=1.
  - acc_clear=1 exactly one cycle after the 16th f_valid.
  - Frame counter returns to 0.
- Within a frame, f_in=0xFFFF0 then 0x00010:
  - Second entry has out_wrap=1; wrap_seen=1.
  - All later entries of that frame have out_wrap=1.
  - First entry of the next frame has out_wrap=0.
- out_ready=0, 10 valid samples:
  - 8 entries are stored; samples 9 and 10 are dropped.
  - overflow=1, drop_count=2, out_data holds the first sample.
  - Then raise out_ready: 8 pops in stored order.
- FIFO full, out_ready=1 and f_valid together: the pop and the push both occur, drop_count is unchanged, and occupancy stays 8.
- Assert reset with 5 entries buffered mid-frame:
  - Next cycle out_valid=0, all flags 0, frame counter 0.
  - Following frame requires 16 samples before acc_clear.
